// File: rtl/score_keeper.sv
// Score keeper for a two-team ball game: edge-detects goal flags, tracks both scores,
// sequences serves and post-goal pauses, and drives seven-segment images of the scores.
module score_keeper #(
    parameter int unsigned WIN_SCORE        = 7,
    parameter int unsigned GOAL_HOLD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       score_to_team1,
    input  logic       score_to_team2,
    input  logic       start_button,
    output logic [3:0] team1_score,
    output logic [3:0] team2_score,
    output logic [6:0] team1_hex,
    output logic [6:0] team2_hex,
    output logic       round_active,
    output logic       ball_serve,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGoalHold,
        StMatchOver
    } state_e;

    localparam logic [3:0]  MaxScore = 4'd9;
    localparam logic [3:0]  WinScore = 4'(WIN_SCORE);
    localparam logic [31:0] HoldLast = 32'(GOAL_HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic        start_prev_q, start_prev_d;
    logic        goal1_prev_q, goal1_prev_d;
    logic        goal2_prev_q, goal2_prev_d;
    logic [3:0]  team1_score_q, team1_score_d;
    logic [3:0]  team2_score_q, team2_score_d;
    logic [1:0]  winner_q, winner_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        ball_serve_q, ball_serve_d;

    logic       start_rise, goal1_rise, goal2_rise;
    logic [3:0] team1_inc, team2_inc;

    function automatic logic [6:0] seg7(input logic [3:0] value);
        logic [6:0] segs;
        case (value)
            4'd0:    segs = 7'b1000000;
            4'd1:    segs = 7'b1111001;
            4'd2:    segs = 7'b0100100;
            4'd3:    segs = 7'b0110000;
            4'd4:    segs = 7'b0011001;
            4'd5:    segs = 7'b0010010;
            4'd6:    segs = 7'b0000010;
            4'd7:    segs = 7'b1111000;
            4'd8:    segs = 7'b0000000;
            4'd9:    segs = 7'b0010000;
            default: segs = 7'b1111111;
        endcase
        return segs;
    endfunction

    // Previous-cycle samples feed edge detection in every state.
    assign start_prev_d = start_button;
    assign goal1_prev_d = score_to_team1;
    assign goal2_prev_d = score_to_team2;

    assign start_rise = start_button & ~start_prev_q;
    assign goal1_rise = score_to_team1 & ~goal1_prev_q;
    assign goal2_rise = score_to_team2 & ~goal2_prev_q;

    assign team1_inc = (team1_score_q < MaxScore) ? team1_score_q + 4'd1 : MaxScore;
    assign team2_inc = (team2_score_q < MaxScore) ? team2_score_q + 4'd1 : MaxScore;

    always_comb begin
        state_d       = state_q;
        team1_score_d = team1_score_q;
        team2_score_d = team2_score_q;
        winner_d      = winner_q;
        hold_cnt_d    = hold_cnt_q;
        ball_serve_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d      = StPlay;
                    ball_serve_d = 1'b1;
                end
            end

            StPlay: begin
                if (goal1_rise && goal2_rise) begin
                    // Simultaneous goals are a wash: no point, but the ball is re-served.
                    state_d    = StGoalHold;
                    hold_cnt_d = '0;
                end else if (goal1_rise) begin
                    team1_score_d = team1_inc;
                    if (team1_inc == WinScore) begin
                        state_d  = StMatchOver;
                        winner_d = 2'b01;
                    end else begin
                        state_d    = StGoalHold;
                        hold_cnt_d = '0;
                    end
                end else if (goal2_rise) begin
                    team2_score_d = team2_inc;
                    if (team2_inc == WinScore) begin
                        state_d  = StMatchOver;
                        winner_d = 2'b10;
                    end else begin
                        state_d    = StGoalHold;
                        hold_cnt_d = '0;
                    end
                end
            end

            StGoalHold: begin
                hold_cnt_d = hold_cnt_q + 32'd1;
                if (hold_cnt_q == HoldLast) begin
                    state_d      = StPlay;
                    ball_serve_d = 1'b1;
                end
            end

            StMatchOver: begin
                if (start_rise) begin
                    state_d       = StIdle;
                    team1_score_d = '0;
                    team2_score_d = '0;
                    winner_d      = 2'b00;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            start_prev_q  <= 1'b1;
            goal1_prev_q  <= 1'b1;
            goal2_prev_q  <= 1'b1;
            team1_score_q <= '0;
            team2_score_q <= '0;
            winner_q      <= 2'b00;
            hold_cnt_q    <= '0;
            ball_serve_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_prev_q  <= start_prev_d;
            goal1_prev_q  <= goal1_prev_d;
            goal2_prev_q  <= goal2_prev_d;
            team1_score_q <= team1_score_d;
            team2_score_q <= team2_score_d;
            winner_q      <= winner_d;
            hold_cnt_q    <= hold_cnt_d;
            ball_serve_q  <= ball_serve_d;
        end
    end

    assign team1_score  = team1_score_q;
    assign team2_score  = team2_score_q;
    assign team1_hex    = seg7(team1_score_q);
    assign team2_hex    = seg7(team2_score_q);
    assign round_active = (state_q == StPlay);
    assign ball_serve   = ball_serve_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed match scenarios then random play, every cycle checked
// against a behavioural match model through an expectation queue.
module tb_score_keeper;

    localparam int unsigned WIN  = 3;
    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       goal1 = 1'b0;
    logic       goal2 = 1'b0;
    logic       start = 1'b0;
    logic [3:0] t1_score, t2_score;
    logic [6:0] t1_hex, t2_hex;
    logic       active, serve;
    logic [1:0] winner;

    score_keeper #(
        .WIN_SCORE        (WIN),
        .GOAL_HOLD_CYCLES (HOLD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .score_to_team1 (goal1),
        .score_to_team2 (goal2),
        .start_button   (start),
        .team1_score    (t1_score),
        .team2_score    (t2_score),
        .team1_hex      (t1_hex),
        .team2_hex      (t2_hex),
        .round_active   (active),
        .ball_serve     (serve),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t1;
        int unsigned t2;
        int unsigned win;
        bit          play;
        bit          serve;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned serves_seen = 0;
    int unsigned serves_exp = 0;

    // Match model: phase of play, countdown of remaining pause cycles, plain integer scores.
    typedef enum {MIdle, MPlay, MPause, MOver} phase_e;
    phase_e      phase = MIdle;
    int unsigned m1 = 0, m2 = 0, mwin = 0, pause_left = 0;
    bit          mserve = 0;
    bit          last_g1 = 1, last_g2 = 1, last_st = 1;

    function automatic logic [6:0] seg(input int unsigned v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, want);
        end
    endtask

    task automatic score_goal(input int team);
        int unsigned s;
        s = (team == 1) ? m1 : m2;
        if (s < 9) s = s + 1;
        if (team == 1) m1 = s; else m2 = s;
        if (s == WIN) begin
            phase = MOver;
            mwin  = team;
        end else begin
            phase      = MPause;
            pause_left = HOLD;
        end
    endtask

    task automatic step(input bit r, input bit a, input bit b, input bit s);
        exp_t e;
        bit   ea, eb, es;
        mserve = 0;
        if (!r) begin
            phase = MIdle;
            m1 = 0; m2 = 0; mwin = 0;
            last_g1 = 1; last_g2 = 1; last_st = 1;
        end else begin
            ea = a && !last_g1;
            eb = b && !last_g2;
            es = s && !last_st;
            case (phase)
                MIdle: if (es) begin phase = MPlay; mserve = 1; end
                MPlay: begin
                    if (ea && eb) begin
                        phase      = MPause;
                        pause_left = HOLD;
                    end else if (ea) score_goal(1);
                    else if (eb) score_goal(2);
                end
                MPause: begin
                    pause_left--;
                    if (pause_left == 0) begin phase = MPlay; mserve = 1; end
                end
                MOver: if (es) begin phase = MIdle; m1 = 0; m2 = 0; mwin = 0; end
                default: phase = MIdle;
            endcase
            last_g1 = a; last_g2 = b; last_st = s;
        end
        if (mserve) serves_exp++;
        e.t1 = m1; e.t2 = m2; e.win = mwin; e.play = (phase == MPlay); e.serve = mserve;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit a, input bit b, input bit s);
        @(negedge clk);
        rst_n = r; goal1 = a; goal2 = b; start = s;
        step(r, a, b, s);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle, so each post-edge sample pops one entry.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (serve === 1'b1) serves_seen++;
                chk("team1_score", 32'(t1_score), e.t1);
                chk("team2_score", 32'(t2_score), e.t2);
                chk("team1_hex", 32'(t1_hex), 32'(seg(e.t1)));
                chk("team2_hex", 32'(t2_hex), 32'(seg(e.t2)));
                chk("winner", 32'(winner), e.win);
                chk("round_active", 32'(active), 32'(e.play));
                chk("ball_serve", 32'(serve), 32'(e.serve));
            end
        end
    end

    initial begin
        bit r, a, b, s;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        quiet(2);
        // Start: one serve, then play.
        cyc(1, 0, 0, 1);
        quiet(3);
        // Team1 goal held for 10 cycles counts once; 4-cycle pause then serve.
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
        quiet(3);
        // Simultaneous goals: no point, pause, serve.
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        quiet(8);
        // Team2 wins with three goals; later edges and starts-only-once ignored.
        for (int g = 0; g < 3; g++) begin
            cyc(1, 0, 1, 0);
            quiet(6);
        end
        cyc(1, 1, 1, 0);
        quiet(2);
        cyc(1, 0, 1, 0);
        quiet(2);
        // Start in match-over returns to idle; second start serves.
        cyc(1, 0, 0, 1);
        quiet(3);
        cyc(1, 0, 0, 1);
        quiet(2);
        // Reset on the 2nd pause cycle while team1's flag is high: no goal after release.
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 0);
        quiet(3);
        // Random play with sticky inputs and rare resets.
        a = 0; b = 0; s = 0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(99) != 0);
            if ($urandom_range(3) == 0) a = ~a;
            if ($urandom_range(3) == 0) b = ~b;
            if ($urandom_range(5) == 0) s = ~s;
            cyc(r, a, b, s);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("serve_count", serves_seen, serves_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
